// File: rtl/alu_unit_pkg.sv
// Shared integer-execution definitions: ROB tag width, funct3 decode and {L1,L2} op codes.
// Used by the reservation station, decoder and ALU so encodings never drift apart.
package alu_unit_pkg;

    localparam int ROB_SIZE_WIDTH = 4;

    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SLL  = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SR   = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } alu_f3_t;

    // {op_L1, op_L2}; ops that ignore the qualifier are listed with L2 = 0
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_OR   = 4'b1100;
    localparam logic [3:0] ALU_AND  = 4'b1110;

endpackage

// File: rtl/alu_unit_core.sv
// RV32I register/immediate ALU datapath (module alu_core).
// Latency: purely combinational.
// Backpressure: none; the result is valid whenever the inputs are.
module alu_core
    import alu_unit_pkg::*;
(
    input  logic [2:0]  op_L1,
    input  logic        op_L2,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        case (alu_f3_t'(op_L1))
            F3_ADD:  result = op_L2 ? (a - b) : (a + b);
            F3_SLL:  result = a << shamt;
            F3_SLT:  result = {31'd0, ($signed(a) < $signed(b))};
            F3_SLTU: result = {31'd0, (a < b)};
            F3_XOR:  result = a ^ b;
            // op_L2 picks arithmetic (sign-filling) over logical right shift
            F3_SR:   result = op_L2 ? 32'($signed(a) >>> shamt) : (a >> shamt);
            F3_OR:   result = a | b;
            F3_AND:  result = a & b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_unit.sv
// Integer execution unit: registers the ALU result and broadcasts {value, ROB id} for one cycle.
// Latency: 1 cycle from issue edge to broadcast; rdy_in low freezes all state.
// Backpressure: none; every accepted op broadcasts exactly once unless flushed by clear_in.
module alu_unit
    import alu_unit_pkg::*;
#(
    parameter int ROB_W = ROB_SIZE_WIDTH
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             clear_in,
    input  logic             rs2alu_ready,
    input  logic [2:0]       rs2alu_op_L1,
    input  logic             rs2alu_op_L2,
    input  logic [31:0]      rs2alu_opr1,
    input  logic [31:0]      rs2alu_opr2,
    input  logic [ROB_W-1:0] rs2alu_rob_id,
    output logic             alu_valid,
    output logic [31:0]      alu_value,
    output logic [ROB_W-1:0] alu_dependency
);

    logic [31:0] core_result;

    alu_core u_core (
        .op_L1  (rs2alu_op_L1),
        .op_L2  (rs2alu_op_L2),
        .a      (rs2alu_opr1),
        .b      (rs2alu_opr2),
        .result (core_result)
    );

    // value/dependency are only loaded on a live issue so they hold across idle and flush cycles
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            alu_valid      <= 1'b0;
            alu_value      <= '0;
            alu_dependency <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                alu_valid <= 1'b0;
            end else if (rs2alu_ready) begin
                alu_valid      <= 1'b1;
                alu_value      <= core_result;
                alu_dependency <= rs2alu_rob_id;
            end else begin
                alu_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_alu_unit;
    import alu_unit_pkg::*;

    localparam int RW = ROB_SIZE_WIDTH;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          rdy_in = 1'b1;
    logic          clear_in = 1'b0;
    logic          rs2alu_ready = 1'b0;
    logic [2:0]    rs2alu_op_L1 = '0;
    logic          rs2alu_op_L2 = 1'b0;
    logic [31:0]   rs2alu_opr1 = '0;
    logic [31:0]   rs2alu_opr2 = '0;
    logic [RW-1:0] rs2alu_rob_id = '0;
    logic          alu_valid;
    logic [31:0]   alu_value;
    logic [RW-1:0] alu_dependency;

    int n_cmp = 0;
    int n_err = 0;

    alu_unit dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .clear_in       (clear_in),
        .rs2alu_ready   (rs2alu_ready),
        .rs2alu_op_L1   (rs2alu_op_L1),
        .rs2alu_op_L2   (rs2alu_op_L2),
        .rs2alu_opr1    (rs2alu_opr1),
        .rs2alu_opr2    (rs2alu_opr2),
        .rs2alu_rob_id  (rs2alu_rob_id),
        .alu_valid      (alu_valid),
        .alu_value      (alu_value),
        .alu_dependency (alu_dependency)
    );

    always #5 clk_in = ~clk_in;

    // Reference ALU from the RV32I rules: shifts as repeated single-bit moves, compares on widened integers
    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic l2,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        longint      sa, sb;
        int          sh;
        sh = int'(b % 32);
        sa = a[31] ? (longint'(a) - 64'sd4294967296) : longint'(a);
        sb = b[31] ? (longint'(b) - 64'sd4294967296) : longint'(b);
        r  = a;
        case (f3)
            3'd0: r = l2 ? 32'(longint'(a) - longint'(b)) : 32'(longint'(a) + longint'(b));
            3'd1: for (int i = 0; i < sh; i++) r = {r[30:0], 1'b0};
            3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd3: r = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: for (int i = 0; i < sh; i++) r = {(l2 ? r[31] : 1'b0), r[31:1]};
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    task automatic drive(input logic rdy, input logic clr, input logic iss, input logic [2:0] f3,
                         input logic l2, input logic [31:0] a, input logic [31:0] b,
                         input logic [RW-1:0] rob);
        rdy_in = rdy; clear_in = clr; rs2alu_ready = iss;
        rs2alu_op_L1 = f3; rs2alu_op_L2 = l2;
        rs2alu_opr1 = a; rs2alu_opr2 = b; rs2alu_rob_id = rob;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 32'd0, 32'd0, '0);
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if ({alu_valid, alu_value, alu_dependency} !== '0) begin
            n_err++;
            $display("FAIL reset_init: got v=%0b val=%h dep=%0d, want all zero", alu_valid, alu_value, alu_dependency);
        end
        @(negedge clk_in);
        rst_in = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 3'd6, 1'b0, 32'hF0F0_0000, 32'h0000_0F0F, 4'd9);
        tick();
        n_cmp++;
        if ({alu_valid, alu_value, alu_dependency} !== {1'b1, 32'hF0F0_0F0F, 4'd9}) begin
            n_err++;
            $display("FAIL reset_preload: got v=%0b val=%h dep=%0d, want v=1 val=f0f00f0f dep=9", alu_valid, alu_value, alu_dependency);
        end
        drive(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 32'd1, 32'd1, 4'd2);
        #2 rst_in = 1'b1;
        #1;
        n_cmp++;
        if ({alu_valid, alu_value, alu_dependency} !== '0) begin
            n_err++;
            $display("FAIL reset_async: got v=%0b val=%h dep=%0d, want all zero before edge", alu_valid, alu_value, alu_dependency);
        end
        idle();
        #1 rst_in = 1'b0;
        tick();
        n_cmp++;
        if (alu_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got v=%0b, want 0", alu_valid);
        end
    endtask

    task automatic test_add_sub();
        drive(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 32'h7FFF_FFFF, 32'd1, 4'd3);
        tick();
        n_cmp++;
        if ({alu_valid, alu_value, alu_dependency} !== {1'b1, 32'h8000_0000, 4'd3}) begin
            n_err++;
            $display("FAIL add_wrap: got v=%0b val=%h dep=%0d, want v=1 val=80000000 dep=3", alu_valid, alu_value, alu_dependency);
        end
        drive(1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 32'd0, 32'd1, 4'd4);
        tick();
        n_cmp++;
        if ({alu_valid, alu_value, alu_dependency} !== {1'b1, 32'hFFFF_FFFF, 4'd4}) begin
            n_err++;
            $display("FAIL sub_wrap: got v=%0b val=%h dep=%0d, want v=1 val=ffffffff dep=4", alu_valid, alu_value, alu_dependency);
        end
        idle();
        tick();
        n_cmp++;
        if ({alu_valid, alu_value} !== {1'b0, 32'hFFFF_FFFF}) begin
            n_err++;
            $display("FAIL idle_after_sub: got v=%0b val=%h, want v=0 val=ffffffff held", alu_valid, alu_value);
        end
    endtask

    task automatic test_shift_cmp();
        drive(1'b1, 1'b0, 1'b1, 3'd5, 1'b1, 32'h8000_0000, 32'h21, 4'd2);
        tick();
        n_cmp++;
        if ({alu_valid, alu_value, alu_dependency} !== {1'b1, 32'hC000_0000, 4'd2}) begin
            n_err++;
            $display("FAIL sra_shamt: got v=%0b val=%h dep=%0d, want v=1 val=c0000000 dep=2", alu_valid, alu_value, alu_dependency);
        end
        drive(1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 32'h8000_0000, 32'h21, 4'd2);
        tick();
        n_cmp++;
        if (alu_value !== 32'h4000_0000) begin
            n_err++;
            $display("FAIL srl_shamt: got %h, want 40000000", alu_value);
        end
        drive(1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1, 4'd5);
        tick();
        n_cmp++;
        if ({alu_valid, alu_value, alu_dependency} !== {1'b1, 32'd1, 4'd5}) begin
            n_err++;
            $display("FAIL slt_signed: got v=%0b val=%h dep=%0d, want v=1 val=1 dep=5", alu_valid, alu_value, alu_dependency);
        end
        drive(1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 32'hFFFF_FFFF, 32'd1, 4'd6);
        tick();
        n_cmp++;
        if ({alu_valid, alu_value, alu_dependency} !== {1'b1, 32'd0, 4'd6}) begin
            n_err++;
            $display("FAIL sltu_unsigned: got v=%0b val=%h dep=%0d, want v=1 val=0 dep=6", alu_valid, alu_value, alu_dependency);
        end
        idle();
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 32'(i * 100), 32'd7, RW'(i));
            tick();
            n_cmp++;
            if ({alu_valid, alu_value, alu_dependency} !== {1'b1, 32'(i * 100 + 7), RW'(i)}) begin
                n_err++;
                $display("FAIL b2b_%0d: got v=%0b val=%h dep=%0d, want v=1 val=%h dep=%0d", i, alu_valid, alu_value, alu_dependency, 32'(i * 100 + 7), i);
            end
        end
        idle();
        tick();
        n_cmp++;
        if (alu_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_end: got v=%0b, want 0", alu_valid);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 32'd5, 32'd5, 4'd5);
        tick();
        n_cmp++;
        if (alu_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_same_cycle: got v=%0b dep=%0d, want v=0", alu_valid, alu_dependency);
        end
        drive(1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 32'h00FF_00FF, 32'h0F0F_0F0F, 4'd6);
        tick();
        n_cmp++;
        if ({alu_valid, alu_value, alu_dependency} !== {1'b1, 32'h0FF0_0FF0, 4'd6}) begin
            n_err++;
            $display("FAIL flush_prior_issue: got v=%0b val=%h dep=%0d, want v=1 val=0ff00ff0 dep=6", alu_valid, alu_value, alu_dependency);
        end
        drive(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 4'd0);
        tick();
        n_cmp++;
        if (alu_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_after: got v=%0b, want 0", alu_valid);
        end
        idle();
        tick();
    endtask

    task automatic test_rdy();
        drive(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 32'd10, 32'd20, 4'd7);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, (i == 1), 1'b1, 3'd7, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 4'd9);
            tick();
            n_cmp++;
            if ({alu_valid, alu_value, alu_dependency} !== {1'b1, 32'd30, 4'd7}) begin
                n_err++;
                $display("FAIL rdy_freeze_%0d: got v=%0b val=%h dep=%0d, want v=1 val=1e dep=7", i, alu_valid, alu_value, alu_dependency);
            end
        end
        idle();
        tick();
        n_cmp++;
        if ({alu_valid, alu_value, alu_dependency} !== {1'b0, 32'd30, 4'd7}) begin
            n_err++;
            $display("FAIL rdy_resume: got v=%0b val=%h dep=%0d, want v=0 val=1e dep=7", alu_valid, alu_value, alu_dependency);
        end
    endtask

    task automatic test_random();
        logic          m_valid;
        logic [31:0]   m_value;
        logic [RW-1:0] m_dep;
        logic          r, c, s, l2;
        logic [2:0]    f3;
        logic [31:0]   a, b;
        logic [RW-1:0] rob;
        m_valid = alu_valid; m_value = alu_value; m_dep = alu_dependency;
        for (int n = 0; n < 400; n++) begin
            r   = ($urandom_range(0, 9) != 0);
            c   = ($urandom_range(0, 9) == 0);
            s   = ($urandom_range(0, 9) < 6);
            f3  = 3'($urandom_range(0, 7));
            l2  = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 ^ 32'($urandom_range(0, 3)) : $urandom;
            b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            rob = RW'($urandom);
            drive(r, c, s, f3, l2, a, b, rob);
            if (r) begin
                if (c) m_valid = 1'b0;
                else if (s) begin
                    m_valid = 1'b1;
                    m_value = ref_alu(f3, (f3 == 3'd0 || f3 == 3'd5) ? l2 : 1'b0, a, b);
                    m_dep   = rob;
                end else m_valid = 1'b0;
            end
            tick();
            n_cmp++;
            if ({alu_valid, alu_value, alu_dependency} !== {m_valid, m_value, m_dep}) begin
                n_err++;
                $display("FAIL random_%0d: f3=%0d l2=%0b a=%h b=%h got v=%0b val=%h dep=%0d, want v=%0b val=%h dep=%0d",
                         n, f3, l2, a, b, alu_valid, alu_value, alu_dependency, m_valid, m_value, m_dep);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_shift_cmp();
        test_back_to_back();
        test_flush();
        test_rdy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
